spi_slave: RTL and testbench
============================

# spi_slave

SPI target (slave) endpoint, the counterpart of the team's `spi_master`, for FPGA-side peripherals addressed over a 4-wire SPI bus. It oversamples the external SCK, CS and MOSI pins in the `clk` domain. It deserialises MOSI into parallel words with a one-cycle valid strobe and serialises a buffered transmit word onto MISO. Multiple back-to-back words may be exchanged within one CS-low frame.

## Interface
- SPI_MODE, 0: SPI mode 0..3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
- SPI_WIDTH, 8: word length in bits, 4..32.
- SPI_MSB, 1: 1 = MSB first, 0 = LSB first, on both MOSI and MISO.
- clk  in  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
- rst_n  in  1  asynchronous active-low reset.
- SCK  in  1  SPI clock from the master, asynchronous to clk.
- CS  in  1  chip select, active low, asynchronous.
- MOSI  in  1  master-out data, asynchronous.
- MISO  out  1  slave-out data.
- tx_data  in  SPI_WIDTH  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty; a transfer occurs when tx_valid && tx_ready on a clk edge.
- rx_data  out  SPI_WIDTH  last complete received word; held until the next word completes.
- rx_valid  out  1  one-clk pulse when rx_data updates.
- tx_underrun  out  1  one-clk pulse when a word starts with an empty holding register.

## Operation
- SCK, CS and MOSI each pass through a 2-flop synchroniser. A third SCK flop provides rise/fall detect, and a third CS flop provides CS fall/rise detect.
- Sample edge: rising when CPOL == CPHA (modes 0 and 3), falling otherwise. The shift edge is the opposite edge.
- FSM states:
  - IDLE to ACTIVE on synchronised CS fall.
  - ACTIVE to IDLE on synchronised CS rise.
  - Any state to IDLE on reset.
- Word start occurs at CS fall and again after every completed word within the frame.
- At word start, the tx shift register loads the holding register and sets tx_ready = 1.
  - If the holding register is empty, the tx shift register loads all zeros and tx_underrun pulses.
- CPHA = 0: MISO presents the first bit at word start, then advances one bit on each shift edge.
- CPHA = 1: MISO advances on each shift edge, including the leading edge of the word.
- On each sample edge, the synchronised MOSI bit is shifted into the rx register per SPI_MSB, and the bit counter increments.
- When the counter reaches SPI_WIDTH:
  - rx_data takes the assembled word and rx_valid pulses.
  - The counter returns to 0 and the next word starts.
- The holding register is written when tx_valid && tx_ready; tx_ready then drops to 0.
- A load from the holding register and a new write in the same cycle are both honoured: the old word is shifted out and the new word occupies the holding register.

## Timing
- Reset values: MISO 0, rx_data 0, rx_valid 0, tx_ready 1, tx_underrun 0, FSM IDLE, counters 0.
- SCK must run at no more than clk/8. CS setup to the first SCK edge, and CS hold after the last SCK edge, must each be at least 4 clk.
- rx_valid asserts 3 clk after the final sample edge at the pins (2 synchroniser + 1 edge detect).
- The MISO update lags the shift edge at the pins by 3 clk, which fits within half an SCK period at the allowed ratio.
- CS rise mid-word:
  - Return to IDLE and clear the counter; no rx_valid; the partial word is discarded.
  - The word already in the tx shift register is lost. The holding register and tx_ready keep their state.
- SCK edges are ignored while in IDLE.
- CS glitches shorter than 2 clk may be missed; no behaviour is defined for them.
- Reset asserted mid-frame: all outputs return to reset values immediately, asynchronously.

## Configuration
- SPI_SLAVE_MISO_TRISTATE_EN defined: MISO is driven only in ACTIVE and is 1'bz in IDLE and during reset, so multiple slaves can share the bus line.
- SPI_SLAVE_MISO_TRISTATE_EN undefined: MISO is always driven and is 0 in IDLE.

## Test plan
- Mode 0, width 8, MSB first, tx_data = 0xA5 preloaded. Master sends 0x3C with SCK = clk/8 → rx_data = 0x3C, exactly one rx_valid pulse, master receives 0xA5, tx_ready rises at CS fall.
- Mode 3, LSB first. Master sends 0x81, then 0x7E, in one CS frame; tx holds 0x12 and 0x34 (second word written after tx_ready) → two rx_valid pulses with 0x81 and 0x7E; master receives 0x12 and 0x34; no tx_underrun.
- Mode 1 with an empty holding register. Master sends 0xFF → tx_underrun pulses once at CS fall, master receives 0x00, rx_data = 0xFF.
- Mode 2. CS rises after 5 of 8 bits → no rx_valid, rx_data keeps its old value. The next full frame receives correctly with the counter starting from 0.
- rst_n asserted mid-word in mode 0 → MISO 0 (or z with SPI_SLAVE_MISO_TRISTATE_EN), tx_ready 1. A full frame after reset release succeeds.
- SPI_WIDTH = 16, mode 0. Master sends 0xBEEF → rx_data = 0xBEEF, rx_valid 3 clk after the 16th rising SCK edge.

Source files
------------

// File: rtl/spi_slave.sv
// SPI target endpoint: oversamples SCK/CS/MOSI in the clk domain, one word per SPI_WIDTH sample edges.
// Build option: define SPI_SLAVE_MISO_TRISTATE_EN to release MISO (1'bz) outside an active frame.
module spi_slave #(
  parameter int SPI_MODE  = 0,
  parameter int SPI_WIDTH = 8,
  parameter bit SPI_MSB   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SCK,
  input  logic                 CS,
  input  logic                 MOSI,
  output logic                 MISO,
  input  logic [SPI_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [SPI_WIDTH-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 tx_underrun
);

  localparam bit CPOL = ((SPI_MODE >> 1) & 1) != 0;
  localparam bit CPHA = (SPI_MODE & 1) != 0;
  localparam int W    = SPI_WIDTH;
  localparam int CW   = $clog2(SPI_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(SPI_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state;
  logic [2:0]    sck_q, cs_q;
  logic [1:0]    mosi_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rx_sr, tx_sr, hold_q, rx_next, load_word;
  logic          miso_q, und_pend;
  logic          sck_rise, sck_fall, sample_edge, shift_edge, shift_ok, bit_edge;
  logic          cs_fall, cs_rise, word_done, load, wr;

  function automatic logic first_bit(input logic [W-1:0] w);
    return SPI_MSB ? w[W-1] : w[0];
  endfunction

  function automatic logic [W-1:0] shift_out(input logic [W-1:0] w);
    return SPI_MSB ? {w[W-2:0], 1'b0} : {1'b0, w[W-1:1]};
  endfunction

  // SCK flops reset to the idle level so reset release never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= {3{CPOL}};
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], SCK};
      cs_q   <= {cs_q[1:0], CS};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign sck_rise    = sck_q[1] & ~sck_q[2];
  assign sck_fall    = ~sck_q[1] & sck_q[2];
  assign sample_edge = (CPOL == CPHA) ? sck_rise : sck_fall;
  assign shift_edge  = (CPOL == CPHA) ? sck_fall : sck_rise;
  assign cs_fall     = ~cs_q[1] & cs_q[2];
  assign cs_rise     = cs_q[1] & ~cs_q[2];

  // With CPHA=0 the first bit is already on MISO at word start, so the trailing
  // edge that follows a word's last sample must not advance it.
  assign shift_ok  = shift_edge & (CPHA | (cnt != '0));
  assign bit_edge  = sample_edge | shift_ok;
  assign word_done = (state == ACTIVE) & ~cs_rise & sample_edge & (cnt == LAST);
  assign load      = ((state == IDLE) & cs_fall) | word_done;
  assign wr        = tx_valid & tx_ready;
  assign load_word = tx_ready ? '0 : hold_q;
  assign rx_next   = SPI_MSB ? {rx_sr[W-2:0], mosi_q[1]} : {mosi_q[1], rx_sr[W-1:1]};

  // Holding register: a same-cycle load takes the old contents, the write wins the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      tx_ready <= 1'b1;
    end else if (wr) begin
      hold_q   <= tx_data;
      tx_ready <= 1'b0;
    end else if (load) begin
      tx_ready <= 1'b1;
    end
  end

  // An empty load after a completed word only counts as underrun once the master
  // actually clocks the next word; a CS rise first means the frame simply ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      miso_q      <= 1'b0;
      und_pend    <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (load) begin
        if (CPHA) begin
          tx_sr <= load_word;
        end else begin
          miso_q <= first_bit(load_word);
          tx_sr  <= shift_out(load_word);
        end
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            cnt         <= '0;
            tx_underrun <= tx_ready;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state    <= IDLE;
            cnt      <= '0;
            miso_q   <= 1'b0;
            und_pend <= 1'b0;
          end else begin
            if (bit_edge && und_pend) begin
              tx_underrun <= 1'b1;
              und_pend    <= 1'b0;
            end
            if (sample_edge) begin
              rx_sr <= rx_next;
              if (cnt == LAST) begin
                cnt      <= '0;
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                und_pend <= tx_ready;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else if (shift_ok) begin
              miso_q <= first_bit(tx_sr);
              tx_sr  <= shift_out(tx_sr);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign MISO = (state == ACTIVE) ? miso_q : 1'bz;
`else
  assign MISO = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: five instances cover modes 0..3, LSB-first and a 16-bit word.
module tb_spi_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sck, mosi;
  logic [4:0]  cs, tx_valid, miso, tx_ready, rx_valid, tx_underrun;
  logic [15:0] txd;
  logic [7:0]  rxd [4];
  logic [15:0] rxd16;
  int nerr = 0, nchk = 0;
  int rv_cnt [5] = '{0, 0, 0, 0, 0};
  int un_cnt [5] = '{0, 0, 0, 0, 0};
  logic [15:0] mi, mi2;
  int lat, r, u;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  logic miso_idle = 1'bz;
`else
  logic miso_idle = 1'b0;
`endif

  spi_slave #(.SPI_MODE(0), .SPI_WIDTH(8), .SPI_MSB(1'b1)) u_m0 (
    .clk(clk), .rst_n(rst_n), .SCK(sck), .CS(cs[0]), .MOSI(mosi), .MISO(miso[0]),
    .tx_data(txd[7:0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .rx_data(rxd[0]), .rx_valid(rx_valid[0]), .tx_underrun(tx_underrun[0]));
  spi_slave #(.SPI_MODE(3), .SPI_WIDTH(8), .SPI_MSB(1'b0)) u_m3 (
    .clk(clk), .rst_n(rst_n), .SCK(sck), .CS(cs[1]), .MOSI(mosi), .MISO(miso[1]),
    .tx_data(txd[7:0]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .rx_data(rxd[1]), .rx_valid(rx_valid[1]), .tx_underrun(tx_underrun[1]));
  spi_slave #(.SPI_MODE(1), .SPI_WIDTH(8), .SPI_MSB(1'b1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .SCK(sck), .CS(cs[2]), .MOSI(mosi), .MISO(miso[2]),
    .tx_data(txd[7:0]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .rx_data(rxd[2]), .rx_valid(rx_valid[2]), .tx_underrun(tx_underrun[2]));
  spi_slave #(.SPI_MODE(2), .SPI_WIDTH(8), .SPI_MSB(1'b1)) u_m2 (
    .clk(clk), .rst_n(rst_n), .SCK(sck), .CS(cs[3]), .MOSI(mosi), .MISO(miso[3]),
    .tx_data(txd[7:0]), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
    .rx_data(rxd[3]), .rx_valid(rx_valid[3]), .tx_underrun(tx_underrun[3]));
  spi_slave #(.SPI_MODE(0), .SPI_WIDTH(16), .SPI_MSB(1'b1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .SCK(sck), .CS(cs[4]), .MOSI(mosi), .MISO(miso[4]),
    .tx_data(txd), .tx_valid(tx_valid[4]), .tx_ready(tx_ready[4]),
    .rx_data(rxd16), .rx_valid(rx_valid[4]), .tx_underrun(tx_underrun[4]));

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rx_valid[i] === 1'b1) rv_cnt[i]++;
      if (tx_underrun[i] === 1'b1) un_cnt[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [15:0] d);
    txd = d;
    tx_valid[idx] = 1'b1;
    wclk(1);
    tx_valid[idx] = 1'b0;
  endtask

  task automatic cs_lo(input int idx, input int mode);
    sck = (mode >= 2);
    wclk(2);
    cs[idx] = 1'b0;
    wclk(8);
  endtask

  task automatic cs_hi(input int idx);
    wclk(4);
    cs[idx] = 1'b1;
    wclk(6);
  endtask

  // Master side: half SCK period is 4 clk; MISO captured just before each sample edge
  task automatic xfer(input int idx, input int mode, input int width, input int nbits,
                      input bit msb, input logic [15:0] mo,
                      output logic [15:0] mr, output int lt);
    bit cpol, cpha, seen;
    int b;
    cpol = (mode >= 2);
    cpha = (mode % 2) == 1;
    mr = '0;
    lt = 0;
    for (int i = 0; i < nbits; i++) begin
      b = msb ? width - 1 - i : i;
      if (!cpha) begin
        mosi = mo[b];
        wclk(4);
        mr[b] = miso[idx];
        sck = ~cpol;
      end else begin
        sck = ~cpol;
        mosi = mo[b];
        wclk(4);
        mr[b] = miso[idx];
        sck = cpol;
      end
      if (i == nbits - 1) begin
        seen = 1'b0;
        for (int j = 0; j < 5; j++) begin
          wclk(1);
          if (!seen && rx_valid[idx] === 1'b1) begin
            seen = 1'b1;
            lt = j + 1;
          end
        end
      end else begin
        wclk(4);
      end
      if (!cpha) sck = cpol;
    end
  endtask

  initial begin
    rst_n = 1'b0; cs = '1; tx_valid = '0; sck = 1'b0; mosi = 1'b0; txd = '0;
    wclk(3);
    chk("rst_miso", miso[0], miso_idle);
    chk("rst_rxd", rxd[0], 8'h00);
    chk("rst_rxv", rx_valid, 5'h00);
    chk("rst_txr", tx_ready, 5'h1f);
    chk("rst_und", tx_underrun, 5'h00);
    rst_n = 1'b1;
    wclk(3);

    // mode 0, preloaded 0xA5, master sends 0x3C
    wr(0, 16'h00A5);
    chk("t1_txr_full", tx_ready[0], 1'b0);
    r = rv_cnt[0]; u = un_cnt[0];
    cs_lo(0, 0);
    chk("t1_txr_rise", tx_ready[0], 1'b1);
    xfer(0, 0, 8, 8, 1'b1, 16'h003C, mi, lat);
    cs_hi(0);
    chk("t1_rxd", rxd[0], 8'h3C);
    chk("t1_rv", rv_cnt[0] - r, 1);
    chk("t1_miso", mi, 16'h00A5);
    chk("t1_und", un_cnt[0] - u, 0);
    chk("t1_lat", lat, 3);

    // mode 3 LSB-first, two words in one frame
    wr(1, 16'h0012);
    r = rv_cnt[1]; u = un_cnt[1];
    cs_lo(1, 3);
    wr(1, 16'h0034);
    xfer(1, 3, 8, 8, 1'b0, 16'h0081, mi, lat);
    chk("t2_rxd1", rxd[1], 8'h81);
    xfer(1, 3, 8, 8, 1'b0, 16'h007E, mi2, lat);
    cs_hi(1);
    chk("t2_rxd2", rxd[1], 8'h7E);
    chk("t2_rv", rv_cnt[1] - r, 2);
    chk("t2_miso1", mi, 16'h0012);
    chk("t2_miso2", mi2, 16'h0034);
    chk("t2_und", un_cnt[1] - u, 0);

    // mode 1, empty holding register
    r = rv_cnt[2]; u = un_cnt[2];
    cs_lo(2, 1);
    xfer(2, 1, 8, 8, 1'b1, 16'h00FF, mi, lat);
    cs_hi(2);
    chk("t3_und", un_cnt[2] - u, 1);
    chk("t3_miso", mi, 16'h0000);
    chk("t3_rxd", rxd[2], 8'hFF);
    chk("t3_rv", rv_cnt[2] - r, 1);

    // mode 2: full word, aborted word, full word
    cs_lo(3, 2);
    xfer(3, 2, 8, 8, 1'b1, 16'h005A, mi, lat);
    cs_hi(3);
    chk("t4_rxd_a", rxd[3], 8'h5A);
    r = rv_cnt[3];
    cs_lo(3, 2);
    wr(3, 16'h00E7);
    xfer(3, 2, 8, 5, 1'b1, 16'h00C3, mi, lat);
    cs_hi(3);
    chk("t4_rxd_keep", rxd[3], 8'h5A);
    chk("t4_rv_none", rv_cnt[3] - r, 0);
    chk("t4_txr_held", tx_ready[3], 1'b0);
    r = rv_cnt[3];
    cs_lo(3, 2);
    xfer(3, 2, 8, 8, 1'b1, 16'h0096, mi, lat);
    cs_hi(3);
    chk("t4_rxd_c", rxd[3], 8'h96);
    chk("t4_rv_c", rv_cnt[3] - r, 1);
    chk("t4_miso_c", mi, 16'h00E7);

    // mode 0, reset mid-word then a clean frame
    wr(0, 16'h00FF);
    cs_lo(0, 0);
    xfer(0, 0, 8, 3, 1'b1, 16'h0000, mi, lat);
    wclk(4);
    chk("t5_part_miso", mi, 16'h00E0);
    chk("t5_pre_miso", miso[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_miso", miso[0], miso_idle);
    chk("t5_rst_txr", tx_ready[0], 1'b1);
    chk("t5_rst_rxd", rxd[0], 8'h00);
    cs[0] = 1'b1;
    wclk(2);
    rst_n = 1'b1;
    wclk(4);
    wr(0, 16'h005C);
    r = rv_cnt[0];
    cs_lo(0, 0);
    xfer(0, 0, 8, 8, 1'b1, 16'h0069, mi, lat);
    cs_hi(0);
    chk("t5_rxd", rxd[0], 8'h69);
    chk("t5_miso", mi, 16'h005C);
    chk("t5_rv", rv_cnt[0] - r, 1);

    // 16-bit word, mode 0
    r = rv_cnt[4];
    cs_lo(4, 0);
    xfer(4, 0, 16, 16, 1'b1, 16'hBEEF, mi, lat);
    cs_hi(4);
    chk("t6_rxd", rxd16, 16'hBEEF);
    chk("t6_lat", lat, 3);
    chk("t6_rv", rv_cnt[4] - r, 1);
    chk("t6_miso", mi, 16'h0000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
